// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption sequencer. Owns the 128-bit cipher state and steps it
// through an external combinational round datapath once per clock. The initial
// AddRoundKey (key whitening) is done here on the accepting edge. After that the
// datapath result is registered once per round until round NR. The ciphertext
// is then latched and a one-cycle done pulse is raised.
//
// Parameters
//   NR  number of rounds (10/12/14 for AES-128/192/256)
//   RW  round counter width, 2**RW > NR
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      encrypt request, honoured only while ready=1
//   ready      high in IDLE
//   busy       high in ROUND and DONE
//   data_in    plaintext, captured on the accepting edge
//   key_round  index of the round key wanted from the key schedule
//   round_key  round key for key_round (combinational from the key schedule)
//   rd_state   state fed to the round datapath
//   rd_last    final round flag, datapath skips MixColumns
//   rd_result  round datapath output
//   data_out   ciphertext, held until the next block completes
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic          busy,
    input  logic [127:0]  data_in,
    output logic [RW-1:0] key_round,
    input  logic [127:0]  round_key,
    output logic [127:0]  rd_state,
    output logic          rd_last,
    input  logic [127:0]  rd_result,
    output logic [127:0]  data_out,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    localparam logic [RW-1:0] RND_LAST = RW'(NR);
    localparam logic [RW-1:0] RND_ONE  = RW'(1);

    fsm_t          fsm_q, fsm_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  data_out_q, data_out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RW-1:0] key_round_q, key_round_d;
    logic          rd_last_q, rd_last_d;

    always_comb begin
        fsm_d      = fsm_q;
        rnd_d      = rnd_q;
        state_d    = state_q;
        data_out_d = data_out_q;

        case (fsm_q)
            S_IDLE: begin
                // key_round is 0 in IDLE, so round_key is the whitening key
                if (start) begin
                    state_d = data_in ^ round_key;
                    rnd_d   = RND_ONE;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = rd_result;
                if (rnd_q == RND_LAST) begin
                    data_out_d = rd_result;
                    fsm_d      = S_DONE;
                end else begin
                    rnd_d = rnd_q + RND_ONE;
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
                rnd_d = '0;
            end
            default: begin
                fsm_d = S_IDLE;
                rnd_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        ready_d     = (fsm_d == S_IDLE);
        busy_d      = (fsm_d == S_ROUND) || (fsm_d == S_DONE);
        done_d      = (fsm_d == S_DONE);
        key_round_d = (fsm_d == S_ROUND) ? rnd_d : '0;
        rd_last_d   = (fsm_d == S_ROUND) && (rnd_d == RND_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            data_out_q  <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_round_q <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_round_q <= key_round_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_round = key_round_q;
    assign rd_last   = rd_last_q;
    assign rd_state  = state_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Bench for aes_round_ctrl. It builds an AES round datapath and a key expansion
// around two sequencer instances: one with NR=10 (AES-128) and one with NR=14
// (AES-256). Each launched block pushes its expected ciphertext and completion
// cycle into a scoreboard queue. Monitors pop the queue on every done pulse.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb14[$];
    exp_t e_mon, e_mon14;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic clk = 1'b0;
    logic rst;
    logic stub;

    logic         start, ready, busy, rd_last, done;
    logic [3:0]   key_round;
    logic [127:0] data_in, round_key, rd_state, rd_result, data_out;
    logic [1919:0] rk_flat;

    logic         start14, ready14, busy14, rd_last14, done14;
    logic [3:0]   key_round14;
    logic [127:0] data_in14, round_key14, rd_state14, rd_result14, data_out14;
    logic [1919:0] rk14;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq = x; inv = 8'h01;
        // x^254 = product of x^(2^k) for k = 1..7; zero maps to zero
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] s [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o ^ k;
    endfunction

    // Round key r lives at bits [r*128 +: 128]
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [1919:0] o;
        rcon = 8'h01;
        o = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    assign round_key   = stub ? {124'b0, key_round} : rk_flat[int'(key_round)*128 +: 128];
    assign rd_result   = stub ? rd_state : aes_round(rd_state, round_key, rd_last);
    assign round_key14 = rk14[int'(key_round14)*128 +: 128];
    assign rd_result14 = aes_round(rd_state14, round_key14, rd_last14);

    aes_round_ctrl #(.NR(10), .RW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy),
        .data_in(data_in), .key_round(key_round), .round_key(round_key),
        .rd_state(rd_state), .rd_last(rd_last), .rd_result(rd_result),
        .data_out(data_out), .done(done)
    );

    aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .ready(ready14), .busy(busy14),
        .data_in(data_in14), .key_round(key_round14), .round_key(round_key14),
        .rd_state(rd_state14), .rd_last(rd_last14), .rd_result(rd_result14),
        .data_out(data_out14), .done(done14)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 128'(done), 128'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("data_out", data_out, e_mon.ct);
                chk("done_cycle", 128'(cyc), 128'(e_mon.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done14 === 1'b1) begin
            if (sb14.size() == 0) begin
                chk("done14_unexpected", 128'(done14), 128'd0);
            end else begin
                e_mon14 = sb14.pop_front();
                chk("data_out14", data_out14, e_mon14.ct);
                chk("done14_cycle", 128'(cyc), 128'(e_mon14.cyc));
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic launch(input logic [127:0] pt, input logic [127:0] ct, input bit push);
        exp_t x;
        data_in = pt;
        start   = 1'b1;
        if (push) begin
            x.ct  = ct;
            x.cyc = cyc + 1 + 10;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_kr(input int k);
        int n;
        n = 0;
        while (key_round !== 4'(k) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("wait_key_round_timeout", 128'(key_round), 128'(k));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},     128'(ready),     128'd1);
        chk({tag, "_busy"},      128'(busy),      128'd0);
        chk({tag, "_done"},      128'(done),      128'd0);
        chk({tag, "_key_round"}, 128'(key_round), 128'd0);
        chk({tag, "_rd_last"},   128'(rd_last),   128'd0);
        chk({tag, "_rd_state"},  rd_state,        128'd0);
        chk({tag, "_data_out"},  data_out,        128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        rst = 1'b1; start = 1'b0; start14 = 1'b0; stub = 1'b0;
        data_in = '0; data_in14 = '0;
        rk_flat = expand({K1, 128'h0}, 4, 10);
        rk14    = expand(K256, 8, 14);
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // C.1 AES-128 vector
        launch(PT1, CT1, 1);
        repeat (12) @(negedge clk);

        // sequencing with pass-through datapath
        stub = 1'b1;
        chk("seq_kr_idle", 128'(key_round), 128'd0);
        launch(128'h0, 128'h0, 1);
        for (int i = 1; i <= 11; i++) begin
            chk("seq_key_round", 128'(key_round), 128'((i <= 10) ? i : 0));
            chk("seq_rd_last", 128'(rd_last), 128'(i == 10));
            @(negedge clk);
        end
        chk("seq_ready_after", 128'(ready), 128'd1);
        stub = 1'b0;
        @(negedge clk);

        // start while busy is ignored
        launch(PT1, CT1, 1);
        wait_kr(3);
        data_in = PTB; start = 1'b1;
        chk("busy_ready_r3", 128'(ready), 128'd0);
        @(negedge clk);
        start = 1'b0;
        wait_kr(10);
        data_in = PTB; start = 1'b1;
        chk("busy_ready_r10", 128'(ready), 128'd0);
        chk("busy_rd_last_r10", 128'(rd_last), 128'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ready_done", 128'(ready), 128'd0);
        chk("busy_busy_done", 128'(busy), 128'd1);
        @(negedge clk);
        chk("busy_ready_idle", 128'(ready), 128'd1);
        repeat (5) @(negedge clk);

        // back-to-back with start held high
        data_in = PT1; start = 1'b1;
        x.ct = CT1; x.cyc = cyc + 11; sb.push_back(x);
        x.ct = CTB; x.cyc = cyc + 23; sb.push_back(x);
        @(negedge clk);
        data_in = PTB;
        repeat (10) @(negedge clk);
        rk_flat = expand({KB, 128'h0}, 4, 10);
        @(negedge clk);
        chk("b2b_ready_gap", 128'(ready), 128'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_second", 128'(busy), 128'd1);
        chk("b2b_hold_early", data_out, CT1);
        repeat (7) @(negedge clk);
        chk("b2b_hold_late", data_out, CT1);
        repeat (4) @(negedge clk);

        // reset during round 5
        rk_flat = expand({K1, 128'h0}, 4, 10);
        launch(PT1, 128'h0, 0);
        wait_kr(5);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(PT1, CT1, 1);
        repeat (12) @(negedge clk);

        // NR=14 instance with the AES-256 vector
        data_in14 = PT1; start14 = 1'b1;
        x.ct = CT256; x.cyc = cyc + 1 + 14; sb14.push_back(x);
        @(negedge clk);
        start14 = 1'b0;
        repeat (16) @(negedge clk);

        chk("sb_empty", 128'(sb.size()), 128'd0);
        chk("sb14_empty", 128'(sb14.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
